// File: rtl/dmem_pkg.sv
// Shared encodings for the wait-stated data memory: access sizes, FSM states,
// the latched request record and the request legality rule.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Everything about an accepted request except its word index, which is
  // sized by the memory depth and therefore kept next to the memory.
  typedef struct packed {
    logic        is_rd;
    logic        bad;
    logic [1:0]  size;
    logic        sign_ext;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  function automatic logic req_bad(input logic       rd,
                                   input logic       wr,
                                   input logic [1:0] size,
                                   input logic [1:0] off);
    logic misaligned;
    misaligned = ((size == SZ_HALF) && off[0]) ||
                 ((size == SZ_WORD) && (off != 2'b00));
    return (rd && wr) || (size == SZ_ILL) || misaligned;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for a little-endian 32-bit word: write merge under a
// size/offset lane mask, and read extraction with sign or zero extension.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  logic [3:0]  lane_mask;
  logic [31:0] wdata_sh;
  logic [31:0] word_sh;

  assign wdata_sh = wdata_i << {off_i, 3'b000};
  assign word_sh  = word_i >> {off_i, 3'b000};

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    lane_mask = 4'b0000;
    case (size_i)
      SZ_BYTE: lane_mask = 4'b0001 << off_i;
      SZ_HALF: lane_mask = 4'b0011 << off_i;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i]) merged_o[8*i +: 8] = wdata_sh[8*i +: 8];
    end
  end

  always_comb begin
    rdata_o = word_sh;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{sign_ext_i & word_sh[7]}},  word_sh[7:0]};
      SZ_HALF: rdata_o = {{16{sign_ext_i & word_sh[15]}}, word_sh[15:0]};
      default: rdata_o = word_sh;
    endcase
  end

endmodule

// File: rtl/dmem_waitstate.sv
// Single-port data memory with a fixed number of wait states per access,
// byte/half/word access sizes, and err reporting for rejected requests.
module dmem_waitstate
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int DBG_INDEX   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err,
  output logic [7:0]  dbg_byte
);

  localparam int               IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]       WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [IDX_W-1:0] DBG_WORD  = IDX_W'(DBG_INDEX / 4);
  localparam int               DBG_LANE  = DBG_INDEX % 4;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  req_t             req_q, req_d, req_in, req_cur;
  logic [IDX_W-1:0] idx_q, idx_d, cur_idx;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic        accept;
  logic        load_rdata;
  logic        mem_we;
  logic [31:0] cur_word;
  logic [31:0] merged_word;
  logic [31:0] lane_rdata;
  logic        addr_unused;

  // Upper address bits alias onto the same words.
  assign addr_unused = ^addr[31:IDX_W+2];

  always_comb begin
    req_in          = '0;
    req_in.is_rd    = rd;
    req_in.bad      = req_bad(rd, wr, size, addr[1:0]);
    req_in.size     = size;
    req_in.sign_ext = sign_ext;
    req_in.off      = addr[1:0];
    req_in.wdata    = wdata;
  end

  assign accept = (state_q == ST_IDLE) && cs && (rd || wr);

  // With no wait states the read is captured on the accept edge itself, so
  // the lane logic must see the live request while idle.
  assign req_cur  = (state_q == ST_IDLE) ? req_in : req_q;
  assign cur_idx  = (state_q == ST_IDLE) ? addr[IDX_W+1:2] : idx_q;
  assign cur_word = mem_q[cur_idx];

  dmem_lane u_lane (
    .size_i     (req_cur.size),
    .sign_ext_i (req_cur.sign_ext),
    .off_i      (req_cur.off),
    .wdata_i    (req_cur.wdata),
    .word_i     (cur_word),
    .merged_o   (merged_word),
    .rdata_o    (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = req_in;
          idx_d = addr[IDX_W+1:2];
          if (WAIT_CYCLES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // rdata is loaded on the edge that enters DONE so it is valid alongside ready.
  assign load_rdata = (state_d == ST_DONE) && (state_q != ST_DONE) &&
                      req_cur.is_rd && !req_cur.bad;
  assign rdata_d    = load_rdata ? lane_rdata : rdata_q;

  assign mem_we = (state_q == ST_DONE) && !req_q.is_rd && !req_q.bad && !rst;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; contents
  // survive rst and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cur_idx] <= merged_word;
  end

  assign ready    = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign err      = ready && req_q.bad;
  assign rdata    = rdata_q;
  assign dbg_byte = mem_q[DBG_WORD][8*DBG_LANE +: 8];

endmodule

// File: tb/tb_dmem_waitstate.sv
// Randomized bench for dmem_waitstate: one instance with two wait states and
// one with none, both checked against a byte-array reference model.
module tb_dmem_waitstate;
  import dmem_pkg::*;

  localparam int DEPTH      = 1024;
  localparam int NBYTES     = DEPTH * 4;
  localparam int DBG        = 1;
  localparam int INIT_WORDS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        cs       [2];
  logic        rd       [2];
  logic        wr       [2];
  logic [1:0]  size     [2];
  logic        sign_ext [2];
  logic [31:0] addr     [2];
  logic [31:0] wdata    [2];
  logic [31:0] rdata    [2];
  logic        ready    [2];
  logic        busy     [2];
  logic        err      [2];
  logic [7:0]  dbg_byte [2];

  dmem_waitstate #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .DBG_INDEX(DBG)) dut_w2 (
    .clk(clk), .rst(rst[0]), .cs(cs[0]), .rd(rd[0]), .wr(wr[0]), .size(size[0]),
    .sign_ext(sign_ext[0]), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
    .ready(ready[0]), .busy(busy[0]), .err(err[0]), .dbg_byte(dbg_byte[0])
  );

  dmem_waitstate #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .DBG_INDEX(DBG)) dut_w0 (
    .clk(clk), .rst(rst[1]), .cs(cs[1]), .rd(rd[1]), .wr(wr[1]), .size(size[1]),
    .sign_ext(sign_ext[1]), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
    .ready(ready[1]), .busy(busy[1]), .err(err[1]), .dbg_byte(dbg_byte[1])
  );

  int          wait_of [2] = '{2, 0};
  logic [7:0]  ref_mem [2][NBYTES];
  bit          ref_vld [2][NBYTES];
  logic [31:0] ref_rdata [2];
  bit          ref_rd_known [2];
  int          tests_run;
  int          tests_failed;

  // Reference: byte-addressed array, address taken modulo the memory size.
  task automatic ref_model(input int d, input bit r, input bit w, input logic [1:0] sz,
                           input bit sx, input logic [31:0] a, input logic [31:0] wd,
                           output bit exp_err, output logic [31:0] exp_rd, output bit known);
    int nb, base;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a & 32'(NBYTES - 1));
    exp_err = (r && w) || (sz == 2'b11) || ((int'(a[1:0]) % nb) != 0);
    if (!exp_err && w) begin
      for (int i = 0; i < nb; i++) begin
        ref_mem[d][(base + i) % NBYTES] = wd[8*i +: 8];
        ref_vld[d][(base + i) % NBYTES] = 1'b1;
      end
    end
    if (!exp_err && r) begin
      v = 32'h0;
      ref_rd_known[d] = 1'b1;
      for (int i = 0; i < nb; i++) begin
        v[8*i +: 8] = ref_mem[d][(base + i) % NBYTES];
        if (!ref_vld[d][(base + i) % NBYTES]) ref_rd_known[d] = 1'b0;
      end
      if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      ref_rdata[d] = v;
    end
    exp_rd = ref_rdata[d];
    known  = ref_rd_known[d];
  endtask

  task automatic idle_inputs(input int d);
    cs[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
    addr[d] = $urandom; wdata[d] = $urandom;
    size[d] = 2'($urandom_range(0, 3)); sign_ext[d] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_req(input int d, input bit r, input bit w, input logic [1:0] sz,
                           input bit sx, input logic [31:0] a, input logic [31:0] wd);
    cs[d] = 1'b1; rd[d] = r; wr[d] = w; size[d] = sz;
    sign_ext[d] = sx; addr[d] = a; wdata[d] = wd;
  endtask

  // One complete access: checks latency, err, rdata, busy and dbg_byte timing.
  task automatic do_access(input int d, input bit r, input bit w, input logic [1:0] sz,
                           input bit sx, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] obs_rd, output logic obs_err);
    bit exp_err, known, dbg_chk;
    logic [31:0] exp_rd;
    logic [7:0] dbg_old;
    int lat;
    dbg_old = ref_mem[d][DBG];
    dbg_chk = ref_vld[d][DBG];
    ref_model(d, r, w, sz, sx, a, wd, exp_err, exp_rd, known);
    @(negedge clk);
    drive_req(d, r, w, sz, sx, a, wd);
    @(posedge clk);
    lat = 0;
    obs_rd = 'x;
    obs_err = 1'bx;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1) idle_inputs(d);
      if (ready[d] === 1'b1 || lat >= 40) break;
    end
    tests_run++;
    if (ready[d] !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_timeout dut%0d addr=%h: no ready within %0d cycles", d, a, lat);
      return;
    end
    obs_rd = rdata[d];
    obs_err = err[d];
    tests_run++;
    if (lat != wait_of[d] + 1) begin
      tests_failed++;
      $display("FAIL latency dut%0d addr=%h: got %0d expected %0d", d, a, lat, wait_of[d] + 1);
    end
    tests_run++;
    if (err[d] !== exp_err) begin
      tests_failed++;
      $display("FAIL err dut%0d r=%0d w=%0d sz=%0d addr=%h: got %b expected %b",
               d, r, w, sz, a, err[d], exp_err);
    end
    tests_run++;
    if (busy[d] !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_at_ready dut%0d: got %b expected 1", d, busy[d]);
    end
    if (known) begin
      tests_run++;
      if (rdata[d] !== exp_rd) begin
        tests_failed++;
        $display("FAIL rdata dut%0d r=%0d sz=%0d sx=%0d addr=%h: got %h expected %h",
                 d, r, sz, sx, a, rdata[d], exp_rd);
      end
    end
    if (dbg_chk) begin
      tests_run++;
      if (dbg_byte[d] !== dbg_old) begin
        tests_failed++;
        $display("FAIL dbg_early dut%0d: got %h expected %h", d, dbg_byte[d], dbg_old);
      end
    end
    @(negedge clk);
    tests_run++;
    if (ready[d] !== 1'b0 || busy[d] !== 1'b0 || err[d] !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_ready dut%0d: got ready=%b busy=%b err=%b expected 0 0 0",
               d, ready[d], busy[d], err[d]);
    end
    if (ref_vld[d][DBG]) begin
      tests_run++;
      if (dbg_byte[d] !== ref_mem[d][DBG]) begin
        tests_failed++;
        $display("FAIL dbg_byte dut%0d: got %h expected %h", d, dbg_byte[d], ref_mem[d][DBG]);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d);
      rst[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if (rdata[d] !== 32'h0 || ready[d] !== 1'b0 || busy[d] !== 1'b0 || err[d] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset dut%0d: got rdata=%h ready=%b busy=%b err=%b expected all zero",
                 d, rdata[d], ready[d], busy[d], err[d]);
      end
      rst[d] = 1'b0;
      ref_rdata[d] = 32'h0;
      ref_rd_known[d] = 1'b1;
    end
  endtask

  task automatic init_mem();
    logic [31:0] o;
    logic e;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < INIT_WORDS; i++)
        do_access(d, 0, 1, SZ_WORD, 0, 32'(i * 4), $urandom, o, e);
  endtask

  task automatic test_word_rw();
    logic [31:0] o;
    logic e;
    do_access(0, 0, 1, SZ_WORD, 0, 32'h8, 32'hDEAD_BEEF, o, e);
    do_access(0, 1, 0, SZ_WORD, 0, 32'h8, 32'h0, o, e);
    tests_run++;
    if (o !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL word_rw: got %h expected DEADBEEF", o);
    end
  endtask

  task automatic test_byte_ext();
    logic [31:0] o;
    logic e;
    do_access(0, 0, 1, SZ_BYTE, 0, 32'h9, 32'h0000_0080, o, e);
    do_access(0, 1, 0, SZ_BYTE, 1, 32'h9, 32'h0, o, e);
    tests_run++;
    if (o !== 32'hFFFF_FF80) begin
      tests_failed++;
      $display("FAIL byte_sext: got %h expected FFFFFF80", o);
    end
    do_access(0, 1, 0, SZ_BYTE, 0, 32'h9, 32'h0, o, e);
    tests_run++;
    if (o !== 32'h0000_0080) begin
      tests_failed++;
      $display("FAIL byte_zext: got %h expected 00000080", o);
    end
    do_access(0, 1, 0, SZ_WORD, 0, 32'h8, 32'h0, o, e);
    tests_run++;
    if (o !== 32'hDEAD_80EF) begin
      tests_failed++;
      $display("FAIL byte_merge: got %h expected DEAD80EF", o);
    end
  endtask

  task automatic test_reject();
    logic [31:0] o;
    logic e;
    do_access(0, 1, 0, SZ_HALF, 1, 32'h3, 32'h0, o, e);
    tests_run++;
    if (e !== 1'b1 || o !== 32'hDEAD_80EF) begin
      tests_failed++;
      $display("FAIL misaligned_half: got err=%b rdata=%h expected err=1 rdata=DEAD80EF", e, o);
    end
    do_access(0, 0, 1, SZ_WORD, 0, 32'h2, 32'h5555_5555, o, e);
    tests_run++;
    if (e !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_word: got err=%b expected 1", e);
    end
    do_access(0, 1, 0, SZ_WORD, 0, 32'h0, 32'h0, o, e);
    do_access(0, 1, 0, SZ_WORD, 0, 32'h4, 32'h0, o, e);
    do_access(0, 1, 0, SZ_ILL, 0, 32'h8, 32'h0, o, e);
    tests_run++;
    if (e !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_size: got err=%b expected 1", e);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] o, xr;
    logic e;
    bit xe, xk;
    int lat, pulses;
    do_access(0, 1, 1, SZ_WORD, 0, 32'h10, 32'h0, o, e);
    tests_run++;
    if (e !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_and_wr: got err=%b expected 1", e);
    end
    ref_model(0, 0, 1, SZ_WORD, 0, 32'h20, 32'hA5A5_0F0F, xe, xr, xk);
    @(negedge clk);
    drive_req(0, 0, 1, SZ_WORD, 0, 32'h20, 32'hA5A5_0F0F);
    @(posedge clk);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (ready[0] === 1'b1 || lat >= 40) break;
      drive_req(0, lat[0], !lat[0], SZ_WORD, 0, 32'h24, 32'h1111_2222);
    end
    tests_run++;
    if (ready[0] !== 1'b1 || lat != 3) begin
      tests_failed++;
      $display("FAIL busy_latency: got ready=%b after %0d cycles expected ready after 3", ready[0], lat);
    end
    idle_inputs(0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready[0] !== 1'b0) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL busy_ignored: got %0d extra ready cycles expected 0", pulses);
    end
    do_access(0, 1, 0, SZ_WORD, 0, 32'h24, 32'h0, o, e);
    do_access(0, 1, 0, SZ_WORD, 0, 32'h20, 32'h0, o, e);
    tests_run++;
    if (o !== 32'hA5A5_0F0F) begin
      tests_failed++;
      $display("FAIL busy_first_write: got %h expected A5A50F0F", o);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] o;
    logic e;
    int pulses;
    @(negedge clk);
    drive_req(0, 0, 1, SZ_WORD, 0, 32'h8, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    idle_inputs(0);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (rdata[0] !== 32'h0 || ready[0] !== 1'b0 || busy[0] !== 1'b0 || err[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort_outputs: got rdata=%h ready=%b busy=%b err=%b expected all zero",
               rdata[0], ready[0], busy[0], err[0]);
    end
    rst[0] = 1'b0;
    ref_rdata[0] = 32'h0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready[0] !== 1'b0) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL reset_abort_ready: got %0d ready cycles expected 0", pulses);
    end
    do_access(0, 1, 0, SZ_WORD, 0, 32'h8, 32'h0, o, e);
    tests_run++;
    if (o !== 32'hDEAD_80EF) begin
      tests_failed++;
      $display("FAIL reset_abort_data: got %h expected DEAD80EF", o);
    end
  endtask

  task automatic test_idle_no_effect();
    logic [31:0] o;
    logic e;
    int seen;
    for (int d = 0; d < 2; d++) begin
      seen = 0;
      @(negedge clk);
      drive_req(d, 0, 1, SZ_WORD, 0, 32'h30, 32'hBAD0_BAD0);
      cs[d] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (ready[d] !== 1'b0 || busy[d] !== 1'b0) seen++;
      end
      drive_req(d, 0, 0, SZ_WORD, 0, 32'h30, 32'hBAD0_BAD0);
      repeat (3) begin
        @(negedge clk);
        if (ready[d] !== 1'b0 || busy[d] !== 1'b0) seen++;
      end
      idle_inputs(d);
      tests_run++;
      if (seen != 0) begin
        tests_failed++;
        $display("FAIL idle_no_effect dut%0d: got %0d active cycles expected 0", d, seen);
      end
      do_access(d, 1, 0, SZ_WORD, 0, 32'h30, 32'h0, o, e);
    end
  endtask

  task automatic test_alias_w0();
    logic [31:0] o;
    logic e;
    do_access(1, 0, 1, SZ_WORD, 0, 32'h1000, 32'hC0DE_F00D, o, e);
    do_access(1, 1, 0, SZ_WORD, 0, 32'h0, 32'h0, o, e);
    tests_run++;
    if (o !== 32'hC0DE_F00D) begin
      tests_failed++;
      $display("FAIL alias: got %h expected C0DEF00D", o);
    end
    do_access(1, 0, 1, SZ_BYTE, 0, 32'h1, 32'h0000_005A, o, e);
    tests_run++;
    if (dbg_byte[1] !== 8'h5A) begin
      tests_failed++;
      $display("FAIL dbg_update: got %h expected 5A", dbg_byte[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] o, a;
    logic e;
    int kind;
    logic [1:0] sz, off;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        kind = $urandom_range(0, 8);
        sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        off = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) begin
          if (sz == SZ_WORD) off = 2'b00;
          else if (sz == SZ_HALF) off[0] = 1'b0;
        end
        a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, INIT_WORDS - 1) * 4) | 32'(off);
        do_access(d, kind < 4 || kind == 8, kind >= 4, sz, 1'($urandom_range(0, 1)),
                  a, $urandom, o, e);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    init_mem();
    test_word_rw();
    test_byte_ext();
    test_reject();
    test_busy_ignore();
    test_reset_abort();
    test_idle_no_effect();
    test_alias_w0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
